// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit
// per clock, through a single one-bit full adder.  The result, carry-out and
// two's-complement overflow are registered and held until the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter is wide enough to hold WIDTH, so it never wraps inside an operation
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bitX;
    logic             bitY;
    logic             sumBit;
    logic             carryNext;
    logic             lastBit;
    logic [WIDTH-1:0] shiftNext;

    // Single full-adder step on the current LSBs of the operand shift registers
    always_comb begin
        bitX      = opA_q[0];
        bitY      = opB_q[0];
        sumBit    = bitX ^ bitY ^ carry_q;
        carryNext = (bitX & bitY) | (carry_q & (bitX ^ bitY));
        lastBit   = (count_q == CW'(WIDTH - 1));
        shiftNext = shift_q >> 1;
        shiftNext[WIDTH-1] = sumBit;
    end

    // Next-state logic: accept in IDLE/DONE, shift one bit per cycle in RUN
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        count_d = count_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = b;
                    carry_d = cin;
                    count_d = '0;
                    shift_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opA_d   = opA_q >> 1;
                opB_d   = opB_q >> 1;
                carry_d = carryNext;
                shift_d = shiftNext;
                count_d = count_q + CW'(1);
                if (lastBit) begin
                    // carry_q is the carry into the MSB at this step
                    sum_d   = shiftNext;
                    cout_d  = carryNext;
                    ovf_d   = carry_q ^ carryNext;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority over start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            count_q <= count_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int assertionCount = 0;
    int failCount      = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands with start for one accepting edge; returns at RUN cycle 1
    task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal, input logic cinVal);
        @(negedge clk);
        a     = aVal;
        b     = bVal;
        cin   = cinVal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step negedge by negedge until done, counting busy cycles, bounded
    task automatic waitDone(output int busyCycles, output logic gotDone);
        busyCycles = 0;
        gotDone    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal,
                         input logic cinVal, input logic [WIDTH-1:0] expSum, input logic expCout,
                         input logic expOvf);
        int   busyCycles;
        logic gotDone;
        applyStimulus(aVal, bVal, cinVal);
        waitDone(busyCycles, gotDone);
        checkOutput({tag, "_done"}, 32'(gotDone), 32'd1);
        checkOutput({tag, "_busycycles"}, 32'(busyCycles), 32'd8);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
        checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_held_sum"}, 32'(sum), 32'(expSum));
    endtask

    // Directed scenario sequence
    initial begin
        int   busyCycles;
        int   donePulses;
        logic gotDone;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);

        runOp("add5A33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        runOp("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        runOp("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        runOp("addFFFFc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start pulse on RUN cycle 3 must be ignored; sum holds during RUN
        applyStimulus(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ign_sum_hold", 32'(sum), 32'hFF);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ign_busy", 32'(busy), 32'd1);
        waitDone(busyCycles, gotDone);
        checkOutput("ign_done", 32'(gotDone), 32'd1);
        checkOutput("ign_busycycles", 32'(busyCycles), 32'd5);
        checkOutput("ign_sum", 32'(sum), 32'h30);
        checkOutput("ign_cout", 32'(cout), 32'd0);
        @(negedge clk);
        checkOutput("ign_idle_busy", 32'(busy), 32'd0);
        checkOutput("ign_idle_done", 32'(done), 32'd0);

        // reset on RUN cycle 4, with start also high, aborts the operation
        applyStimulus(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_ovf", 32'(ovf), 32'd0);
        donePulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) donePulses++;
        end
        checkOutput("abort_no_activity", 32'(donePulses), 32'd0);

        // start held high: back-to-back operations, done every 9 cycles
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            waitDone(busyCycles, gotDone);
            checkOutput($sformatf("b2b%0d_done", k), 32'(gotDone), 32'd1);
            checkOutput($sformatf("b2b%0d_busycycles", k), 32'(busyCycles), 32'd8);
            checkOutput($sformatf("b2b%0d_sum", k), 32'(sum), 32'h03);
            checkOutput($sformatf("b2b%0d_busy_in_done", k), 32'(busy), 32'd0);
            if (k == 2) start = 1'b0;
            @(negedge clk);
            if (k < 2) checkOutput($sformatf("b2b%0d_next_busy", k), 32'(busy), 32'd1);
        end
        checkOutput("b2b_end_busy", 32'(busy), 32'd0);
        checkOutput("b2b_end_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule
